// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream-like word channel (tvalid/tready/tdata)
//   master modport: drives tvalid, tdata; receives tready
//   slave  modport: receives tvalid, tdata; drives tready
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_i2c_write_master.sv
// rtl/axis_i2c_write_master.sv - AXI-Stream to I2C register-write master
//   One 16-bit word per frame: START, {SLAVE_ADDR,W}, ACK, tdata[15:8], ACK, tdata[7:0], ACK, STOP.
//   Optional feature macro: I2C_CLK_STRETCH_EN (honour slave clock stretching via scl_i).
//   clk_i    system clock              arstn_i   async active-low reset
//   s_axis   axis_if slave (word in)   scl_i     SCL pad readback
//   sda_i    SDA pad readback          scl_oe_o  1 = pull SCL low
//   sda_oe_o 1 = pull SDA low          busy_o    frame in progress
//   nack_o   one-cycle pulse on a NACKed ACK slot
module axis_i2c_write_master #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 100_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h21,
    parameter int         DATA_WIDTH = 16
) (
    input  logic  clk_i,
    input  logic  arstn_i,
    axis_if.slave s_axis,
    input  logic  scl_i,
    input  logic  sda_i,
    output logic  scl_oe_o,
    output logic  sda_oe_o,
    output logic  busy_o,
    output logic  nack_o
);
    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int CW  = $clog2(DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [1:0]            q;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic [DATA_WIDTH-1:0] word;
    logic                  nack_seen;
    logic                  tready_q;
    logic                  stall;
    logic                  q_end;

    assign s_axis.tready = tready_q;
    assign q_end         = (cnt == CW'(DIV - 1));

`ifdef I2C_CLK_STRETCH_EN
    // SCL has just been released in q1; a slave holding it low freezes the quarter timer.
    assign stall = (q == 2'd1) && (state != START) && (state != IDLE) && !scl_i && (cnt == '0);
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    // Every output change is made on the edge that enters a new quarter, so the
    // pads follow the (state, q) table while staying registered.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            word      <= '0;
            nack_seen <= 1'b0;
            tready_q  <= 1'b0;
            scl_oe_o  <= 1'b0;
            sda_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
            nack_o    <= 1'b0;
        end else begin
            nack_o <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                q   <= 2'd0;
                if (tready_q && s_axis.tvalid) begin
                    word      <= s_axis.tdata;
                    shift     <= {SLAVE_ADDR, 1'b0};
                    bit_cnt   <= 3'd0;
                    nack_seen <= 1'b0;
                    tready_q  <= 1'b0;
                    busy_o    <= 1'b1;
                    state     <= START;
                end else begin
                    tready_q <= 1'b1;
                end
            end else if (stall) begin
                cnt <= '0;
            end else if (!q_end) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                q   <= q + 2'd1;
                case (state)
                    START: begin
                        case (q)
                            2'd1:    sda_oe_o <= 1'b1;
                            2'd2:    scl_oe_o <= 1'b1;
                            2'd3: begin
                                sda_oe_o <= ~shift[7];
                                state    <= ADDR;
                            end
                            default: ;
                        endcase
                    end
                    ADDR, REG, DATA: begin
                        case (q)
                            2'd0:    scl_oe_o <= 1'b0;
                            2'd2:    scl_oe_o <= 1'b1;
                            2'd3: begin
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt  <= 3'd0;
                                    sda_oe_o <= 1'b0;
                                    state    <= (state == ADDR) ? ACK1 :
                                                (state == REG)  ? ACK2 : ACK3;
                                end else begin
                                    bit_cnt  <= bit_cnt + 3'd1;
                                    shift    <= {shift[6:0], 1'b0};
                                    sda_oe_o <= ~shift[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                    ACK1, ACK2, ACK3: begin
                        case (q)
                            2'd0:    scl_oe_o <= 1'b0;
                            2'd2: begin
                                scl_oe_o <= 1'b1;
                                if (sda_i) begin
                                    nack_o    <= 1'b1;
                                    nack_seen <= 1'b1;
                                end
                            end
                            2'd3: begin
                                // SCL is low here, so SDA may move for the next slot.
                                if (nack_seen || state == ACK3) begin
                                    sda_oe_o <= 1'b1;
                                    state    <= STOP;
                                end else if (state == ACK1) begin
                                    shift    <= word[15:8];
                                    sda_oe_o <= ~word[15];
                                    state    <= REG;
                                end else begin
                                    shift    <= word[7:0];
                                    sda_oe_o <= ~word[7];
                                    state    <= DATA;
                                end
                            end
                            default: ;
                        endcase
                    end
                    STOP: begin
                        case (q)
                            2'd0:    scl_oe_o <= 1'b0;
                            2'd1:    sda_oe_o <= 1'b0;
                            2'd3: begin
                                state    <= IDLE;
                                busy_o   <= 1'b0;
                                tready_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_i2c_write_master.sv
// tb/tb_axis_i2c_write_master.sv - scoreboard bench with I2C slave model for axis_i2c_write_master
module tb_axis_i2c_write_master;
    localparam int CLK_FREQ = 50_000_000;
    localparam int I2C_FREQ = 250_000;
    localparam int DIV      = CLK_FREQ / (4 * I2C_FREQ);
    localparam int FRAME    = 116 * DIV;
    localparam int NFRAME   = 44 * DIV;
    localparam int LIMIT    = 4 * FRAME;
    localparam logic [8:0] STOP_TOK = 9'h100;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    axis_if s_axis ();
    logic scl_oe, sda_oe, busy, nack;
    logic slave_ack_drive = 1'b0;
    logic slave_hold = 1'b0;
    logic nack_addr = 1'b0;
    wire  scl = ~scl_oe & ~slave_hold;
    wire  sda = ~sda_oe & ~slave_ack_drive;

    axis_i2c_write_master #(
        .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .SLAVE_ADDR(7'h21), .DATA_WIDTH(16)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .s_axis(s_axis), .scl_i(scl), .sda_i(sda),
        .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .busy_o(busy), .nack_o(nack)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Slave model and bus monitor
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    int bitn = 0, byte_idx = 0, start_cnt = 0, stop_cnt = 0, nack_cnt = 0;
    logic [7:0] sh = 8'h00;
    logic [8:0] tok;

    always @(negedge clk) begin
        if (!arstn) begin
            bitn = 0;
            byte_idx = 0;
            slave_ack_drive = 1'b0;
            prev_scl = 1'b1;
            prev_sda = 1'b1;
        end else begin
            if (busy) check("tready_low_while_busy", int'(s_axis.tready), 0);
            if (nack) nack_cnt++;
            if (prev_scl && scl && prev_sda != sda) begin
                if (!sda) begin
                    start_cnt++;
                    check("start_on_byte_boundary", bitn, 0);
                end else begin
                    stop_cnt++;
                    // the STOP's own SCL rise counts as one captured bit
                    check("stop_on_byte_boundary", bitn, 1);
                    tok = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                    check("stop_token", int'(STOP_TOK), int'(tok));
                end
                bitn = 0;
                byte_idx = 0;
            end else if (!prev_scl && scl) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda};
                    bitn++;
                    if (bitn == 8) begin
                        tok = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                        check("byte", int'({1'b0, sh}), int'(tok));
                    end
                end else begin
                    bitn++;
                end
            end else if (prev_scl && !scl) begin
                if (bitn == 8) begin
                    slave_ack_drive = !(nack_addr && byte_idx == 0);
                end else if (bitn == 9) begin
                    slave_ack_drive = 1'b0;
                    bitn = 0;
                    byte_idx++;
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    int exp_starts = 0;
    int t0 = 0;

    task automatic accept(input logic [15:0] w);
        int n;
        n = 0;
        s_axis.tdata = w;
        s_axis.tvalid = 1'b1;
        while (s_axis.tready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (s_axis.tready !== 1'b1) check("accept_timeout", 0, 1);
        exp_q.push_back(9'h042);
        if (!nack_addr) begin
            exp_q.push_back({1'b0, w[15:8]});
            exp_q.push_back({1'b0, w[7:0]});
        end
        exp_q.push_back(STOP_TOK);
        exp_starts++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_axis.tready !== 1'b1 && n < LIMIT);
        if (s_axis.tready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    initial begin
        repeat (200_000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_nack", int'(nack), 0);
        check("rst_tready", int'(s_axis.tready), 0);
        @(negedge clk);
        arstn = 1'b1;
        #1;
        check("tready_after_release", int'(s_axis.tready), 0);
        @(negedge clk);
        check("tready_idle", int'(s_axis.tready), 1);

        // single ACKed frame
        accept(16'h1280);
        t0 = cyc;
        check("busy_after_accept", int'(busy), 1);
        s_axis.tvalid = 1'b0;
        wait_ready();
        check_range("frame_latency", cyc - t0, FRAME - 2, FRAME + 2);
        check("frame_queue_empty", exp_q.size(), 0);
        check("frame_busy_low", int'(busy), 0);
        check("frame_no_nack", nack_cnt, 0);

        // address NACK
        nack_addr = 1'b1;
        nack_cnt = 0;
        accept(16'h5678);
        t0 = cyc;
        s_axis.tvalid = 1'b0;
        wait_ready();
        check_range("nack_latency", cyc - t0, NFRAME - 2, NFRAME + 2);
        check("nack_pulses", nack_cnt, 1);
        check("nack_queue_empty", exp_q.size(), 0);
        check("nack_busy_low", int'(busy), 0);
        nack_addr = 1'b0;
        nack_cnt = 0;

        // back-to-back with tvalid held
        accept(16'h1180);
        t0 = cyc;
        accept(16'h1200);
        accept(16'h8C00);
        s_axis.tvalid = 1'b0;
        wait_ready();
        check_range("b2b_latency", cyc - t0, 3 * FRAME, 3 * FRAME + 4);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_no_nack", nack_cnt, 0);

        // reset during DATA bit 3
        accept(16'hA55A);
        s_axis.tvalid = 1'b0;
        begin
            int n;
            n = 0;
            while (!(byte_idx == 2 && bitn == 3) && n < LIMIT) begin
                @(posedge clk);
                n++;
            end
            if (!(byte_idx == 2 && bitn == 3)) check("reach_data_bit3", 0, 1);
        end
        #1;
        arstn = 1'b0;
        #1;
        check("midrst_scl_oe", int'(scl_oe), 0);
        check("midrst_sda_oe", int'(sda_oe), 0);
        check("midrst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        accept(16'h3C0F);
        t0 = cyc;
        s_axis.tvalid = 1'b0;
        wait_ready();
        check_range("post_reset_latency", cyc - t0, FRAME - 2, FRAME + 2);
        check("post_reset_queue_empty", exp_q.size(), 0);

`ifdef I2C_CLK_STRETCH_EN
        // slave stretches SCL at REG bit 0 q1
        accept(16'h4D2B);
        t0 = cyc;
        s_axis.tvalid = 1'b0;
        begin
            int n;
            n = 0;
            while (!(byte_idx == 1 && bitn == 0 && scl_oe) && n < LIMIT) begin
                @(posedge clk);
                n++;
            end
            slave_hold = 1'b1;
            n = 0;
            while (scl_oe && n < LIMIT) begin
                @(posedge clk);
                n++;
            end
            if (scl_oe) check("reach_reg_q1", 0, 1);
            repeat (500) @(posedge clk);
            #1;
            slave_hold = 1'b0;
        end
        wait_ready();
        check_range("stretch_latency", cyc - t0, FRAME + 500 - 4, FRAME + 500 + 4);
        check("stretch_queue_empty", exp_q.size(), 0);
`endif

        repeat (5) @(negedge clk);
        check("start_count", start_cnt, exp_starts);
        check("stop_count", stop_cnt, exp_starts - 1);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
